mult_div_unit: RTL and testbench

Iterative multiply/divide unit that owns the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the ALU in EX. The ALU reads oHI/oLO for MFHI/MFLO; this unit replaces the single-cycle HI/LO arithmetic and the fixed-count lock.
- Runs a 32-step radix-2 algorithm.
- Asserts oBusy so the hazard unit stalls the pipeline until the result is committed.

---
 rtl/mult_div_pkg.sv | 18 +
 rtl/mult_div_step.sv | 30 +++
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the default operand width.
package mult_div_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/mult_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor when it fits, record the quotient bit.
module mult_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   div_ext;
    logic [WIDTH-1:0] quot_sh;

    assign rem_sh  = {rem_i[WIDTH-1:0], quot_i[WIDTH-1]};
    assign div_ext = {1'b0, divisor_i};
    assign quot_sh = {quot_i[WIDTH-2:0], 1'b0};

    always_comb begin
        rem_o  = rem_sh;
        quot_o = quot_sh;
        if (rem_sh >= div_ext) begin
            rem_o  = rem_sh - div_ext;
            quot_o = quot_sh | {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO. Optional macro
// MULT_DIV_EARLY_TERM_EN ends a multiply once the remaining multiplier is zero.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iStart,
    input  logic [1:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iMTHI,
    input  logic             iMTLO,
    input  logic [WIDTH-1:0] iMTData,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDivByZero
);

    md_state_e          state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic               bz_q, bz_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_q, dbz_d;

    logic [WIDTH:0]     step_rem;
    logic [WIDTH-1:0]   step_quot;
    logic               op_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;

    mult_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // Signed ops are the even encodings (MULT, DIV).
    assign op_signed = ~iOp[0];
    assign mag_a     = (op_signed && iA[WIDTH-1]) ? -iA : iA;
    assign mag_b     = (op_signed && iB[WIDTH-1]) ? -iB : iB;
    assign prod      = (sa_q ^ sb_q) ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        bz_d      = bz_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    is_div_d  = iOp[1];
                    sa_d      = op_signed & iA[WIDTH-1];
                    sb_d      = op_signed & iB[WIDTH-1];
                    bz_d      = (iB == '0);
                    a_d       = iA;
                    cnt_d     = '0;
                    acc_d     = '0;
                    mcand_d   = {{WIDTH{1'b0}}, mag_a};
                    mplier_d  = mag_b;
                    rem_d     = '0;
                    quot_d    = mag_a;
                    divisor_d = mag_b;
                    state_d   = ST_RUN;
                end else begin
                    if (iMTHI) hi_d = iMTData;
                    if (iMTLO) lo_d = iMTData;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    rem_d  = step_rem;
                    quot_d = step_quot;
                end else begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (cnt_d == CNT_W'(WIDTH)) state_d = ST_FIX;
`ifdef MULT_DIV_EARLY_TERM_EN
                if (!is_div_q && mplier_d == '0) state_d = ST_FIX;
`endif
            end
            ST_FIX: begin
                if (is_div_q) begin
                    if (bz_q) begin
                        hi_d  = a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = (sa_q ^ sb_q) ? -quot_q : quot_q;
                        hi_d = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    end
                end else begin
                    {hi_d, lo_d} = prod;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= ST_IDLE;
            is_div_q  <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            bz_q      <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            bz_q      <= bz_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            a_q       <= a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign oHI        = hi_q;
    assign oLO        = lo_q;
    assign oBusy      = (state_q != ST_IDLE);
    assign oDone      = done_q;
    assign oDivByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops
// compared against a plain-arithmetic model of MULT/MULTU/DIV/DIVU.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         iCLK = 1'b0;
    logic         iRST_n = 1'b0;
    logic         iStart = 1'b0;
    logic [1:0]   iOp = 2'b00;
    logic [W-1:0] iA = '0, iB = '0;
    logic         iMTHI = 1'b0, iMTLO = 1'b0;
    logic [W-1:0] iMTData = '0;
    logic [W-1:0] oHI, oLO;
    logic         oBusy, oDone, oDivByZero;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_hi = '0, exp_lo = '0;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .iCLK       (iCLK),
        .iRST_n     (iRST_n),
        .iStart     (iStart),
        .iOp        (iOp),
        .iA         (iA),
        .iB         (iB),
        .iMTHI      (iMTHI),
        .iMTLO      (iMTLO),
        .iMTData    (iMTData),
        .oHI        (oHI),
        .oLO        (oLO),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oDivByZero (oDivByZero)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference result computed straight from the arithmetic definition.
    task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
        longint sa, sb, q, r;
        logic [63:0] p;
        dbz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    hi = a; lo = 32'hFFFFFFFF; dbz = 1'b1;
                end else if (op == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endtask

    function automatic int exp_busy(input logic [1:0] op, input logic [W-1:0] b);
        int steps;
        logic [W-1:0] mag;
        steps = W;
`ifdef MULT_DIV_EARLY_TERM_EN
        if (!op[1]) begin
            mag = (op == 2'b00 && b[W-1]) ? -b : b;
            steps = 1;
            for (int i = 0; i < W; i++) if (mag[i]) steps = i + 1;
        end
`else
        mag = b;
        if (op[1] && mag == 0) steps = W;
`endif
        return steps + 1;
    endfunction

    // Called #1 after a rising edge with the unit idle; returns in the oDone cycle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise);
        logic [W-1:0] hi, lo;
        logic dbz;
        int cycles;
        model(op, a, b, hi, lo, dbz);
        iOp = op; iA = a; iB = b; iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        iA = $urandom; iB = $urandom; iOp = 2'($urandom);
        check("done_clr", {63'b0, oDone}, 64'd0);
        cycles = 0;
        while (oBusy && cycles < 100) begin
            if (noise && cycles == 5) begin
                iMTHI = 1'b1; iMTLO = 1'b1; iMTData = $urandom; iStart = 1'b1;
            end
            if (cycles == 7) begin
                iMTHI = 1'b0; iMTLO = 1'b0; iStart = 1'b0;
            end
            cycles++;
            @(posedge iCLK); #1;
        end
        iMTHI = 1'b0; iMTLO = 1'b0; iStart = 1'b0;
        check("busy_len", 64'(cycles), 64'(exp_busy(op, b)));
        check("done", {63'b0, oDone}, 64'd1);
        check("hi", {32'b0, oHI}, {32'b0, hi});
        check("lo", {32'b0, oLO}, {32'b0, lo});
        check("dbz", {63'b0, oDivByZero}, {63'b0, dbz});
        exp_hi = hi; exp_lo = lo;
    endtask

    initial begin
        int dones;
        logic [1:0] rop;
        logic [W-1:0] ra, rb;

        #12;
        check("rst_hi", {32'b0, oHI}, 64'd0);
        check("rst_lo", {32'b0, oLO}, 64'd0);
        check("rst_busy", {63'b0, oBusy}, 64'd0);
        check("rst_done", {63'b0, oDone}, 64'd0);
        check("rst_dbz", {63'b0, oDivByZero}, 64'd0);
        iRST_n = 1'b1;
        @(posedge iCLK); #1;

        iMTHI = 1'b1; iMTLO = 1'b1; iMTData = 32'h12345678;
        @(posedge iCLK); #1;
        iMTHI = 1'b0; iMTLO = 1'b0;
        check("mt_hi", {32'b0, oHI}, 64'h12345678);
        check("mt_lo", {32'b0, oLO}, 64'h12345678);
        iMTLO = 1'b1; iMTData = 32'hCAFEF00D;
        @(posedge iCLK); #1;
        iMTLO = 1'b0;
        check("mtlo_hi", {32'b0, oHI}, 64'h12345678);
        check("mtlo_lo", {32'b0, oLO}, 64'hCAFEF00D);

        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b1);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(2'b11, 32'd5, 32'd0, 1'b0);
        run_op(2'b10, 32'hFFFFFFF0, 32'd0, 1'b0);
        run_op(2'b00, 32'd5, 32'd3, 1'b0);
        run_op(2'b00, 32'h80000000, 32'h80000000, 1'b0);

        repeat (4) @(posedge iCLK);
        #1;
        check("hold_hi", {32'b0, oHI}, {32'b0, exp_hi});
        check("hold_lo", {32'b0, oLO}, {32'b0, exp_lo});

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op(rop, ra, rb, 1'(i % 3 == 0) & rop[1]);
        end

        iOp = 2'b01; iA = 32'h00001234; iB = 32'h80000001; iStart = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        repeat (9) @(posedge iCLK);
        #3;
        iRST_n = 1'b0;
        #1;
        check("arst_busy", {63'b0, oBusy}, 64'd0);
        check("arst_hi", {32'b0, oHI}, 64'd0);
        check("arst_lo", {32'b0, oLO}, 64'd0);
        check("arst_done", {63'b0, oDone}, 64'd0);
        @(posedge iCLK); #2;
        iRST_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge iCLK); #1;
            if (oDone) dones++;
        end
        check("arst_nodone", 64'(dones), 64'd0);
        check("arst_idle", {63'b0, oBusy}, 64'd0);

        run_op(2'b00, 32'hFFFFFFFF, 32'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
